// File: rtl/serdes_tx_pkg.sv
// Shared constants for the SERDES TX arbiter: K-char framing words,
// the FSM state encoding and the channel-id width.
package serdes_tx_pkg;

  localparam int          CH_W     = 1;        // two requesters -> 1-bit channel id
  localparam logic [7:0]  K_SOP_HI = 8'h5C;    // K28.2 in the high byte of the SOP word
  localparam logic [15:0] K_EOP    = 16'hFDFD; // K29.7 in both bytes

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_DRAIN = 3'd4
  } tx_state_e;

  // SOP word carries the granted channel id in its low byte
  function automatic logic [15:0] sop_word(input logic [CH_W-1:0] ch);
    return {K_SOP_HI, 8'h00} | 16'(ch);
  endfunction

endpackage

// File: rtl/serdes_tx_arbiter_if.sv
// Request-side and TX-buffer-side signals of the SERDES TX arbiter.
// slave  : the arbiter (consumes requests, drives the TX buffer)
// master : the surroundings (requesters + TX buffer)
interface serdes_tx_arbiter_if;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_sop;
  logic [1:0]  rq_eop;
  logic [15:0] rq_dat0;
  logic [15:0] rq_dat1;
  logic [1:0]  rq_ready;
  logic [15:0] tx_dat_o;
  logic        tx_klsb_o;
  logic        tx_kmsb_o;
  logic        tx_en;
  logic        tx_rdy;

  modport master (
    output rq_valid, rq_sop, rq_eop, rq_dat0, rq_dat1, tx_rdy,
    input  rq_ready, tx_dat_o, tx_klsb_o, tx_kmsb_o, tx_en
  );

  modport slave (
    input  rq_valid, rq_sop, rq_eop, rq_dat0, rq_dat1, tx_rdy,
    output rq_ready, tx_dat_o, tx_klsb_o, tx_kmsb_o, tx_en
  );
endinterface

// File: rtl/serdes_tx_arbiter_rr_arb2.sv
// serdes_rr_arb2: 2-way grant select. On contention either ch1 wins
// outright (CH1_PRIO!=0) or the channel not granted last wins. The
// pointer only moves when the caller commits the grant (take).
module serdes_rr_arb2 import serdes_tx_pkg::*; #(
  parameter int CH1_PRIO = 0
) (
  input  logic            dsp_clk,
  input  logic            dsp_rst_n,
  input  logic [1:0]      req,
  input  logic            take,
  output logic [CH_W-1:0] gnt_id,
  output logic            gnt_any
);

  logic [CH_W-1:0] ptr; // channel preferred on the next contention

  // pick a winner from the current requests
  always_comb begin
    gnt_any = |req;
    if (req == 2'b11) gnt_id = (CH1_PRIO != 0) ? 1'b1 : ptr;
    else              gnt_id = req[1];
  end

  // after a committed grant the other channel becomes preferred
  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n)            ptr <= '0;
    else if (take && gnt_any)  ptr <= ~gnt_id;
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter: grants whole packets from two requesters onto the
// SERDES TX word pipeline, framing each with SOP/EOP K-words. Packets
// longer than MAX_LEN are cut, closed with EOP, and their tail drained.
// Optional feature: define SERDES_TX_ARB_PKT_CNT_EN to add per-channel
// EOP counters pkt_cnt0/pkt_cnt1.
module serdes_tx_arbiter import serdes_tx_pkg::*; #(
  parameter int MAX_LEN   = 256,
  parameter int LEN_WIDTH = 9,
  parameter int CH1_PRIO  = 0
) (
  input  logic                 dsp_clk,
  input  logic                 dsp_rst_n,
  serdes_tx_arbiter_if.slave   bus,
  output logic                 err_trunc
`ifdef SERDES_TX_ARB_PKT_CNT_EN
  ,
  output logic [15:0]          pkt_cnt0,
  output logic [15:0]          pkt_cnt1
`endif
);

  localparam logic [LEN_WIDTH:0] LEN_LIMIT = MAX_LEN[LEN_WIDTH:0];

  tx_state_e            state;
  logic [CH_W-1:0]      gnt;
  logic [LEN_WIDTH-1:0] len;
  logic                 drain;

  logic [1:0]      sop_req;
  logic [CH_W-1:0] arb_id;
  logic            arb_any;
  logic            g_valid, g_eop, xfer, len_hit;
  logic [15:0]     g_dat;
  logic [LEN_WIDTH:0] len_inc;

  assign sop_req = bus.rq_valid & bus.rq_sop;
  assign g_valid = bus.rq_valid[gnt];
  assign g_eop   = bus.rq_eop[gnt];
  assign g_dat   = gnt[0] ? bus.rq_dat1 : bus.rq_dat0;
  assign xfer    = (state == ST_DATA) && g_valid && bus.tx_rdy;
  assign len_inc = {1'b0, len} + 1'b1;
  assign len_hit = (len_inc == LEN_LIMIT);

  serdes_rr_arb2 #(.CH1_PRIO(CH1_PRIO)) u_arb (
    .dsp_clk   (dsp_clk),
    .dsp_rst_n (dsp_rst_n),
    .req       (sop_req),
    .take      (state == ST_IDLE),
    .gnt_id    (arb_id),
    .gnt_any   (arb_any)
  );

  logic [15:0] dat_c;
  logic        klsb_c, kmsb_c, en_c;
  logic [1:0]  rdy_c;

  // per-state output decode; tx_en/rq_ready follow tx_rdy in the same cycle
  always_comb begin
    dat_c  = '0;
    klsb_c = 1'b0;
    kmsb_c = 1'b0;
    en_c   = 1'b0;
    rdy_c  = '0;
    case (state)
      ST_HDR: begin
        dat_c  = sop_word(gnt);
        kmsb_c = 1'b1;
        en_c   = bus.tx_rdy;
      end
      ST_DATA: begin
        dat_c      = g_dat;
        en_c       = g_valid && bus.tx_rdy;
        rdy_c[gnt] = g_valid && bus.tx_rdy;
      end
      ST_EOP: begin
        dat_c  = K_EOP;
        klsb_c = 1'b1;
        kmsb_c = 1'b1;
        en_c   = bus.tx_rdy;
      end
      ST_DRAIN: rdy_c[gnt] = 1'b1; // swallow the truncated tail
      default: ;
    endcase
  end

  assign bus.tx_dat_o  = dat_c;
  assign bus.tx_klsb_o = klsb_c;
  assign bus.tx_kmsb_o = kmsb_c;
  assign bus.tx_en     = en_c;
  assign bus.rq_ready  = rdy_c;

  // packet framing FSM, grant latch, payload length and truncation flag
  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      len       <= '0;
      drain     <= 1'b0;
      err_trunc <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (arb_any) begin
          gnt   <= arb_id;
          state <= ST_HDR;
        end
        ST_HDR: if (bus.tx_rdy) begin
          len   <= '0;
          drain <= 1'b0;
          state <= ST_DATA;
        end
        ST_DATA: if (xfer) begin
          len <= len_inc[LEN_WIDTH-1:0];
          if (g_eop) begin
            state <= ST_EOP;
          end else if (len_hit) begin
            state     <= ST_EOP;
            drain     <= 1'b1;
            err_trunc <= 1'b1;
          end
        end
        ST_EOP: if (bus.tx_rdy) state <= drain ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (g_valid && g_eop) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERDES_TX_ARB_PKT_CNT_EN
  // count EOP words enqueued per channel, free-running wrap
  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (state == ST_EOP && bus.tx_rdy) begin
      if (gnt[0]) pkt_cnt1 <= pkt_cnt1 + 16'd1;
      else        pkt_cnt0 <= pkt_cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Scoreboard bench for serdes_tx_arbiter: packets are generated per
// channel, a packet-level model orders them by the grant rules and pushes
// the framed word stream; a negedge monitor pops and compares each
// enqueued TX word.
module tb_serdes_tx_arbiter;

  localparam int MAX_LEN   = 8;
  localparam int LEN_WIDTH = 4;
  localparam int CH1_PRIO  = 0;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] dat;
  } word_t;

  logic dsp_clk = 1'b0;
  logic dsp_rst_n = 1'b0;
  logic err_trunc;
`ifdef SERDES_TX_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

  serdes_tx_arbiter_if bus();

  serdes_tx_arbiter #(.MAX_LEN(MAX_LEN), .LEN_WIDTH(LEN_WIDTH), .CH1_PRIO(CH1_PRIO)) dut (
    .dsp_clk   (dsp_clk),
    .dsp_rst_n (dsp_rst_n),
    .bus       (bus),
    .err_trunc (err_trunc)
`ifdef SERDES_TX_ARB_PKT_CNT_EN
    ,
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
`endif
  );

  always #5 dsp_clk = ~dsp_clk;

  int n_chk = 0;
  int n_pass = 0;

  // model / scoreboard state
  logic [17:0] exp_q[$];          // {kmsb, klsb, dat}
  word_t       drv_q0[$], drv_q1[$];
  logic [15:0] pk_dat[2][32][16];
  int          pk_len[2][32];
  int          pk_n[2];
  int          last_gnt;           // channel granted most recently
  logic [15:0] exp_cnt[2];
  logic        exp_trunc;
  logic        mon_en = 1'b0;
  logic        rdy1_seen = 1'b0;
  int          rdy_mode = 0;       // 0: always ready, 1: random, 2: toggle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_note(input string nm, input int info);
    n_chk++;
    $display("FAIL %s: info %0d, required condition not met (t=%0t)", nm, info, $time);
  endtask

  task automatic add_pkt(input int ch, input int len, input bit rnd, input logic [15:0] base);
    for (int i = 0; i < len; i++)
      pk_dat[ch][pk_n[ch]][i] = rnd ? 16'($urandom) : base + 16'(i);
    pk_len[ch][pk_n[ch]] = len;
    pk_n[ch]++;
  endtask

  // expected frame of one packet and the words its requester will offer
  task automatic frame(input int c, input int p);
    int n, keep;
    word_t w;
    n    = pk_len[c][p];
    keep = (n > MAX_LEN) ? MAX_LEN : n;
    exp_q.push_back({2'b10, 16'h5C00 | 16'(c)});
    for (int i = 0; i < keep; i++) exp_q.push_back({2'b00, pk_dat[c][p][i]});
    exp_q.push_back({2'b11, 16'hFDFD});
    if (n > MAX_LEN) exp_trunc = 1'b1;
    exp_cnt[c] = exp_cnt[c] + 16'd1;
    for (int i = 0; i < n; i++) begin
      w.sop = (i == 0);
      w.eop = (i == n - 1);
      w.dat = pk_dat[c][p][i];
      if (c == 0) drv_q0.push_back(w);
      else        drv_q1.push_back(w);
    end
  endtask

  // order packets by the grant rule: both pending -> alternate (or ch1 if
  // prioritised); one pending -> it goes
  task automatic build();
    int idx0, idx1, c;
    idx0 = 0;
    idx1 = 0;
    while (idx0 < pk_n[0] || idx1 < pk_n[1]) begin
      if (idx0 < pk_n[0] && idx1 < pk_n[1]) c = (CH1_PRIO != 0) ? 1 : 1 - last_gnt;
      else                                  c = (idx0 < pk_n[0]) ? 0 : 1;
      last_gnt = c;
      if (c == 0) begin frame(0, idx0); idx0++; end
      else        begin frame(1, idx1); idx1++; end
    end
    pk_n[0] = 0;
    pk_n[1] = 0;
  endtask

  // requester: SOP words offered back-to-back, optional gaps inside a packet
  task automatic drive(input int ch, input bit gap_en);
    word_t w;
    int    t;
    logic  acc;
    while ((ch == 0 ? drv_q0.size() : drv_q1.size()) != 0) begin
      if (ch == 0) w = drv_q0.pop_front();
      else         w = drv_q1.pop_front();
      if (!w.sop && gap_en) begin
        bus.rq_valid[ch] = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge dsp_clk); #1; end
      end
      bus.rq_valid[ch] = 1'b1;
      bus.rq_sop[ch]   = w.sop;
      bus.rq_eop[ch]   = w.eop;
      if (ch == 0) bus.rq_dat0 = w.dat;
      else         bus.rq_dat1 = w.dat;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 400) begin
        @(negedge dsp_clk);
        acc = bus.rq_ready[ch];
        @(posedge dsp_clk); #1;
        t++;
      end
      if (!acc) begin
        fail_note("drv_timeout", ch);
        if (ch == 0) drv_q0.delete();
        else         drv_q1.delete();
      end
    end
    bus.rq_valid[ch] = 1'b0;
    bus.rq_sop[ch]   = 1'b0;
    bus.rq_eop[ch]   = 1'b0;
  endtask

  task automatic run_phase(input bit gap_en);
    int t;
    fork
      drive(0, gap_en);
      drive(1, gap_en);
    join
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge dsp_clk); t++; end
    if (exp_q.size() != 0) fail_note("drain_timeout", exp_q.size());
    repeat (3) @(posedge dsp_clk);
    @(negedge dsp_clk);
    chk("err_trunc", err_trunc, exp_trunc);
`ifdef SERDES_TX_ARB_PKT_CNT_EN
    chk("pkt_cnt0", pkt_cnt0, exp_cnt[0]);
    chk("pkt_cnt1", pkt_cnt1, exp_cnt[1]);
`endif
    @(posedge dsp_clk); #1;
  endtask

  // TX buffer readiness pattern
  always @(posedge dsp_clk) begin
    #1;
    case (rdy_mode)
      0:       bus.tx_rdy = 1'b1;
      1:       bus.tx_rdy = ($urandom_range(0, 3) != 0);
      default: bus.tx_rdy = ~bus.tx_rdy;
    endcase
  end

  // monitor: every enqueued word is checked against the scoreboard head
  logic [17:0] mon_exp;
  always @(negedge dsp_clk) begin
    if (mon_en && dsp_rst_n) begin
      if (bus.rq_ready[1]) rdy1_seen = 1'b1;
      if (bus.rq_ready != 2'b00) chk("ready_onehot", {31'd0, &bus.rq_ready}, 32'd0);
      if (bus.tx_en) begin
        chk("tx_en_rdy", {31'd0, bus.tx_rdy}, 32'd1);
        if (exp_q.size() == 0) fail_note("unexpected_word", int'(bus.tx_dat_o));
        else begin
          mon_exp = exp_q.pop_front();
          chk("tx_word", {14'd0, bus.tx_kmsb_o, bus.tx_klsb_o, bus.tx_dat_o}, {14'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t;
    bus.rq_valid = '0;
    bus.rq_sop   = '0;
    bus.rq_eop   = '0;
    bus.rq_dat0  = '0;
    bus.rq_dat1  = '0;
    bus.tx_rdy   = 1'b1;
    pk_n[0] = 0;  pk_n[1] = 0;
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    exp_trunc = 1'b0;
    last_gnt  = 1;

    // reset state
    repeat (3) @(posedge dsp_clk);
    @(negedge dsp_clk);
    chk("rst_tx_en",  {31'd0, bus.tx_en}, 32'd0);
    chk("rst_tx_dat", {16'd0, bus.tx_dat_o}, 32'd0);
    chk("rst_kflags", {30'd0, bus.tx_kmsb_o, bus.tx_klsb_o}, 32'd0);
    chk("rst_ready",  {30'd0, bus.rq_ready}, 32'd0);
    chk("rst_err",    {31'd0, err_trunc}, 32'd0);
    dsp_rst_n = 1'b1;
    mon_en    = 1'b1;
    @(posedge dsp_clk); #1;

    // both channels contend from reset, two packets each
    add_pkt(0, 2, 0, 16'hB000);
    add_pkt(0, 3, 0, 16'hB100);
    add_pkt(1, 1, 0, 16'hB200);
    add_pkt(1, 2, 0, 16'hB300);
    build();
    run_phase(0);

    // single ch0 3-word packet; ch1 never sees ready
    rdy1_seen = 1'b0;
    add_pkt(0, 3, 0, 16'hA001);
    build();
    run_phase(0);
    chk("ch1_ready_idle", {31'd0, rdy1_seen}, 32'd0);

    // tx_rdy toggling every cycle during a 4-word packet
    rdy_mode = 2;
    add_pkt(1, 4, 0, 16'hE000);
    build();
    run_phase(0);

    // random traffic, no packet over MAX_LEN (includes exactly MAX_LEN)
    rdy_mode = 1;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 6; i++) add_pkt(c, $urandom_range(1, MAX_LEN), 1, 16'h0);
    add_pkt(0, MAX_LEN, 1, 16'h0);
    build();
    run_phase(1);

    // truncation: 10 words with eop on the last, then a normal packet
    rdy_mode = 0;
    add_pkt(0, MAX_LEN + 2, 0, 16'hC001);
    add_pkt(1, 2, 0, 16'hD001);
    build();
    run_phase(0);

    // random traffic with some over-length packets
    rdy_mode = 1;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 8; i++) add_pkt(c, $urandom_range(1, MAX_LEN + 4), 1, 16'h0);
    build();
    run_phase(1);

    // reset in the middle of a payload
    rdy_mode = 0;
    mon_en   = 1'b0;
    @(posedge dsp_clk); #1;
    bus.rq_valid[0] = 1'b1;
    bus.rq_sop[0]   = 1'b1;
    bus.rq_eop[0]   = 1'b0;
    bus.rq_dat0     = 16'h7000;
    acc = 0;
    t   = 0;
    while (acc < 3 && t < 50) begin
      @(negedge dsp_clk);
      if (bus.rq_ready[0]) acc++;
      @(posedge dsp_clk); #1;
      bus.rq_sop[0] = 1'b0;
      bus.rq_dat0   = bus.rq_dat0 + 16'd1;
      t++;
    end
    if (acc < 3) fail_note("mid_pkt_timeout", acc);
    #2;
    dsp_rst_n = 1'b0;
    #1;
    chk("arst_tx_en",  {31'd0, bus.tx_en}, 32'd0);
    chk("arst_tx_dat", {16'd0, bus.tx_dat_o}, 32'd0);
    chk("arst_kflags", {30'd0, bus.tx_kmsb_o, bus.tx_klsb_o}, 32'd0);
    chk("arst_ready",  {30'd0, bus.rq_ready}, 32'd0);
    chk("arst_err",    {31'd0, err_trunc}, 32'd0);
    bus.rq_valid = '0;
    bus.rq_sop   = '0;
    @(posedge dsp_clk);
    @(negedge dsp_clk);
    dsp_rst_n  = 1'b1;
    last_gnt   = 1;
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    exp_trunc  = 1'b0;
    exp_q.delete();
    mon_en     = 1'b1;
    @(posedge dsp_clk); #1;
    add_pkt(1, 2, 0, 16'h9000);
    build();
    run_phase(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
